fft_r22sdf_twmul_1024_s2: RTL and testbench
===========================================

# fft_r22sdf_twmul_1024_s2

Twiddle-multiplier stage that sits after the stage-2 butterfly pair of the 1024-point R2²SDF FFT in the MFCC front end. It consumes the butterfly output stream and tracks the 64-sample position within each sub-block. It drives the stage-2 twiddle ROM address, aligns the data with the ROM's one-cycle read latency, and emits the complex product rounded and saturated back to data width. It is the reader/consumer side of the stage-2 twiddle ROM.

## Interface
- `DW`, 16, signed data width of real and imaginary parts.
- `TW`, 10, twiddle width (Q1.9 signed); fixed by the ROM, not user-changeable.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `din_re` in DW: signed real input.
- `din_im` in DW: signed imaginary input.
- `din_vld` in 1: input sample valid.
- `din_sof` in 1: first sample of a 1024-point frame; qualified by `din_vld`.
- `dout_re` out DW: signed real product.
- `dout_im` out DW: signed imaginary product.
- `dout_vld` out 1: output valid.
- `dout_sof` out 1: `din_sof` delayed to align with the output.
- `sat` out 1: pulses with `dout_vld` when either output part saturated.

## Operation
- Position counter `idx` is 6 bits.
  - On `din_vld & din_sof`, the sample uses address 0 and `idx` becomes 1.
  - On `din_vld & !din_sof`, the sample uses address `idx`, then `idx` increments and wraps from 63 to 0.
  - When `din_vld` is low, `idx` holds.
- ROM address is the address used for the current sample, presented combinationally to the ROM sub-module in the same cycle the sample is captured. The ROM `addr_vld` input is tied to `din_vld`.
- Complex multiply, with (a, b) as input and (c, d) as twiddle:
  - re = a·c − b·d
  - im = a·d + b·c
- Products are DW+TW bits; the sum is DW+TW+1 bits, full precision.
- Rounding: add 2^8, then arithmetic shift right by 9 (round half up toward +∞).
- Saturation:
  - A result > 2^(DW−1)−1 clamps to 2^(DW−1)−1.
  - A result < −2^(DW−1) clamps to −2^(DW−1).
  - `sat` is the OR of the real-part and imaginary-part saturation flags.
- Twiddle value −512 (address 24 imaginary part) is legal and must not be special-cased. Full-scale negative input times −512 must saturate.
- Data path is free-running. Valid and sof travel in a shift chain alongside the data; no back-pressure.
- Reset values (asynchronous on `rst_n` low):
  - `idx` = 0.
  - All pipeline data registers, `dout_re`, and `dout_im` = 0.
  - `dout_vld`, `dout_sof`, and `sat` = 0.
- Reset asserted mid-frame discards all in-flight samples. No valid output appears until new inputs arrive.
- Gaps in `din_vld` do not disturb address sequencing.

## Timing
- Cycle 0 (T): sample and address captured (input register); ROM latches the twiddle at the same edge.
- T+1: data register and ROM output aligned; four partial products registered.
- T+2: add/sub, round, saturate; output registers loaded.
- Latency is 3 clock edges from `din_vld` to `dout_vld`. Throughput is one sample per clock.
- `dout_sof` and `sat` are coincident with the matching `dout_vld`.
- Back-to-back frames: a `din_sof` arriving while `idx` ≠ 0 forces address 0 (resync). No error flag is raised.

## Structure
- Shared package `fft_r22sdf_pkg` holds:
  - `TW` = 10 and the Q-format shift constant 9.
  - The rounding constant.
  - A saturate-to-DW function shared with the other stage multipliers.
- One sub-module: `fft_r22sdf_rom_1024_s2`, the stage-2 twiddle ROM with 6-bit address and one-cycle registered read.
- All other logic is local: counter, alignment registers, multiplier, round/saturate.

## Test plan
- Reset, then sof plus 64 samples of (1000, 0): index 0 gives (998, 0); index 20 gives (707, −707). Output arrives exactly 3 cycles after each input.
- Input (0, 1000) at index 59 after sof: output (−98, −996).
- Input (−32768, 0) at index 24: output (0, 32767) with `sat` = 1. Index 0 with the same input gives (−32704, 0) with `sat` = 0.
- Random `din_vld` gaps across two frames compared against a bit-true model: addresses stay contiguous, wrap 63→0 repeats the pattern 16 times per frame, and `dout_sof` aligns with the frame start.
- `din_sof` injected at index 37: that sample uses address 0, and the following sample uses address 1.
- `rst_n` pulsed low with 2 samples in flight: `dout_vld` stays 0 and all outputs read 0. The next sof restarts at address 0.

Source files
------------

// File: rtl/fft_r22sdf_pkg.sv
// fft_r22sdf_pkg: shared twiddle format constants and output saturation for the R2^2SDF stage multipliers
// No ports; imported by the stage multipliers and twiddle ROMs.
package fft_r22sdf_pkg;
   localparam int TW  = 10;
   localparam int QS  = 9;
   localparam int RND = 1 << (QS - 1);
   // Clamp a full-precision rounded result into a dw-bit signed range.
   function automatic logic signed [31:0] sat_dw(input logic signed [31:0] v, input int dw);
      logic signed [31:0] hi, lo;
      hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (dw - 1));
      return (v > hi) ? hi : (v < lo) ? lo : v;
   endfunction
endpackage

// File: rtl/fft_r22sdf_rom_1024_s2.sv
// fft_r22sdf_rom_1024_s2: stage-2 twiddle ROM, 6-bit address, one-cycle registered read
// Ports: clk, rst_n (async active-low); i_addr sub-block position; i_addr_vld read enable;
//        o_tw_re / o_tw_im Q1.9 twiddle, valid the cycle after the address.
module fft_r22sdf_rom_1024_s2
   import fft_r22sdf_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic [5:0]    i_addr,
   input  logic          i_addr_vld,
   output logic [TW-1:0] o_tw_re,
   output logic [TW-1:0] o_tw_im
);
   // round(512*sin(2*pi*k/64)) for k = 0..16; the full 64-point circle is folded onto this quarter
   localparam logic [TW-1:0] SIN_Q [0:16] = '{
      10'd0,   10'd50,  10'd100, 10'd149, 10'd196, 10'd241, 10'd284, 10'd325, 10'd362,
      10'd396, 10'd426, 10'd452, 10'd473, 10'd490, 10'd502, 10'd510, 10'd512};
   logic [1:0]    w_m;
   logic [5:0]    w_e;
   logic          w_q1, w_q2;
   logic [4:0]    w_ka, w_kb;
   logic [TW-1:0] w_re, w_im;
   // Exponent e = n2 * bitrev(n1), where n1 is the quarter of the 64-sample block; e never exceeds 45.
   always_comb begin
      w_m  = {i_addr[4], i_addr[5]};
      w_e  = {2'b00, i_addr[3:0]} * {4'b0000, w_m};
      w_q1 = w_e <= 6'd16;
      w_q2 = w_e <= 6'd32;
      w_ka = w_q1 ? 5'(6'd16 - w_e) : w_q2 ? 5'(w_e - 6'd16) : 5'(6'd48 - w_e);
      w_kb = w_q1 ? 5'(w_e) : w_q2 ? 5'(6'd32 - w_e) : 5'(w_e - 6'd32);
      // cos(0) = +1 is not representable in Q1.9, so it becomes 511; -1 on the imaginary side stays -512
      w_re = !w_q1 ? -SIN_Q[w_ka] : (w_ka == 5'd16) ? 10'd511 : SIN_Q[w_ka];
      w_im = (w_q1 | w_q2) ? -SIN_Q[w_kb] : SIN_Q[w_kb];
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         o_tw_re <= '0;
         o_tw_im <= '0;
      end else if (i_addr_vld) begin
         o_tw_re <= w_re;
         o_tw_im <= w_im;
      end
endmodule

// File: rtl/fft_r22sdf_twmul_1024_s2.sv
// fft_r22sdf_twmul_1024_s2: stage-2 twiddle multiplier of the 1024-point R2^2SDF FFT
// Ports: clk, rst_n (async active-low); din_re/din_im/din_vld/din_sof butterfly stream in;
//        dout_re/dout_im/dout_vld/dout_sof rounded, saturated product 3 edges later; sat saturation pulse.
module fft_r22sdf_twmul_1024_s2
   import fft_r22sdf_pkg::*;
#(
   parameter int DW = 16
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] din_re,
   input  logic [DW-1:0] din_im,
   input  logic          din_vld,
   input  logic          din_sof,
   output logic [DW-1:0] dout_re,
   output logic [DW-1:0] dout_im,
   output logic          dout_vld,
   output logic          dout_sof,
   output logic          sat
);
   localparam int PW = DW + TW;
   localparam int SW = PW + 1;
   logic [5:0]           r_idx, w_addr;
   logic [DW-1:0]        r_re, r_im;
   logic [TW-1:0]        w_tw_re, w_tw_im;
   logic [PW-1:0]        r_ac, r_bd, r_ad, r_bc;
   logic [1:0]           r_vld, r_sof;
   logic signed [SW-1:0] w_sum_re, w_sum_im, w_rnd_re, w_rnd_im;
   logic signed [31:0]   w_sat_re, w_sat_im;
   logic                 w_ovf_re, w_ovf_im;
   function automatic logic [PW-1:0] mul(input logic [DW-1:0] a, input logic [TW-1:0] t);
      return {{TW{a[DW-1]}}, a} * {{DW{t[TW-1]}}, t};
   endfunction
   // A sof always restarts the sub-block at address 0, even mid-block.
   assign w_addr = din_sof ? 6'd0 : r_idx;
   fft_r22sdf_rom_1024_s2 u_rom (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_addr     (w_addr),
      .i_addr_vld (din_vld),
      .o_tw_re    (w_tw_re),
      .o_tw_im    (w_tw_im)
   );
   always_comb begin
      w_sum_re = $signed({r_ac[PW-1], r_ac}) - $signed({r_bd[PW-1], r_bd});
      w_sum_im = $signed({r_ad[PW-1], r_ad}) + $signed({r_bc[PW-1], r_bc});
      w_rnd_re = (w_sum_re + SW'(RND)) >>> QS;
      w_rnd_im = (w_sum_im + SW'(RND)) >>> QS;
      w_sat_re = sat_dw(32'(w_rnd_re), DW);
      w_sat_im = sat_dw(32'(w_rnd_im), DW);
      w_ovf_re = w_sat_re != 32'(w_rnd_re);
      w_ovf_im = w_sat_im != 32'(w_rnd_im);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_idx    <= '0;
         r_re     <= '0;
         r_im     <= '0;
         r_ac     <= '0;
         r_bd     <= '0;
         r_ad     <= '0;
         r_bc     <= '0;
         r_vld    <= '0;
         r_sof    <= '0;
         dout_re  <= '0;
         dout_im  <= '0;
         dout_vld <= 1'b0;
         dout_sof <= 1'b0;
         sat      <= 1'b0;
      end else begin
         if (din_vld) begin
            r_idx <= w_addr + 6'd1;
            r_re  <= din_re;
            r_im  <= din_im;
         end
         r_vld    <= {r_vld[0], din_vld};
         r_sof    <= {r_sof[0], din_vld & din_sof};
         r_ac     <= mul(r_re, w_tw_re);
         r_bd     <= mul(r_im, w_tw_im);
         r_ad     <= mul(r_re, w_tw_im);
         r_bc     <= mul(r_im, w_tw_re);
         dout_re  <= w_sat_re[DW-1:0];
         dout_im  <= w_sat_im[DW-1:0];
         dout_vld <= r_vld[1];
         dout_sof <= r_sof[1];
         sat      <= r_vld[1] & (w_ovf_re | w_ovf_im);
      end
endmodule

// File: tb/tb_fft_r22sdf_twmul_1024_s2.sv
// tb_fft_r22sdf_twmul_1024_s2: directed vectors plus randomized frames against a trigonometric reference model
module tb_fft_r22sdf_twmul_1024_s2;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] din_re = '0, din_im = '0;
   logic        din_vld = 1'b0, din_sof = 1'b0;
   logic [15:0] dout_re, dout_im;
   logic        dout_vld, dout_sof, sat;

   fft_r22sdf_twmul_1024_s2 #(.DW(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .din_re   (din_re),
      .din_im   (din_im),
      .din_vld  (din_vld),
      .din_sof  (din_sof),
      .dout_re  (dout_re),
      .dout_im  (dout_im),
      .dout_vld (dout_vld),
      .dout_sof (dout_sof),
      .sat      (sat)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int passes = 0;
   int m_idx = 0;

   typedef struct {int e_cyc; int re; int im; bit sof; bit sat;} exp_t;
   exp_t q[$];

   typedef struct {int addr; int a; int b; int er; int ei; bit es;} vec_t;
   vec_t tv[7];

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Twiddle W64^(n2*bitrev(n1)) from the trigonometric definition, quantised to Q1.9.
   function automatic void twiddle(input int addr, output int c, output int d);
      int  n1, n2, m, e;
      real th;
      n1 = addr / 16;
      n2 = addr % 16;
      m  = ((n1 & 1) << 1) | (n1 >> 1);
      e  = n2 * m;
      th = 2.0 * 3.141592653589793 * e / 64.0;
      c  = int'($floor(512.0 * $cos(th) + 0.5));
      d  = int'($floor(-512.0 * $sin(th) + 0.5));
      if (c > 511) c = 511;
      if (c < -512) c = -512;
      if (d > 511) d = 511;
      if (d < -512) d = -512;
   endfunction

   function automatic void rsat(input longint v, output int r, output bit s);
      longint t;
      t = (v + 256) >>> 9;
      s = (t > 32767) || (t < -32768);
      r = (t > 32767) ? 32767 : (t < -32768) ? -32768 : int'(t);
   endfunction

   function automatic void model(input int addr, input int a, input int b,
                                 output int re, output int im, output bit s);
      int c, d;
      bit sr, si;
      twiddle(addr, c, d);
      rsat(longint'(a) * c - longint'(b) * d, re, sr);
      rsat(longint'(a) * d + longint'(b) * c, im, si);
      s = sr | si;
   endfunction

   task automatic drive(input bit v, input bit sf, input int a, input int b, output int oe);
      int addr, re, im;
      bit s;
      @(negedge clk);
      din_vld = v;
      din_sof = sf;
      din_re  = 16'(a);
      din_im  = 16'(b);
      oe = cyc + 3;
      if (v) begin
         addr  = sf ? 0 : m_idx;
         m_idx = (addr + 1) % 64;
         model(addr, a, b, re, im, s);
         q.push_back('{oe, re, im, sf, s});
      end
   endtask

   task automatic idle_until(input int oe);
      @(negedge clk);
      din_vld = 1'b0;
      din_sof = 1'b0;
      do begin
         @(posedge clk);
         #1;
      end while (cyc < oe);
   endtask

   always @(posedge clk) begin
      exp_t x;
      #1;
      while (q.size() != 0 && q[0].e_cyc < cyc) begin
         x = q.pop_front();
         chk("missed_output_cycle", cyc, x.e_cyc);
      end
      if (q.size() != 0 && q[0].e_cyc == cyc) begin
         x = q.pop_front();
         chk("mdl_vld", dout_vld, 1);
         chk("mdl_re", $signed(dout_re), x.re);
         chk("mdl_im", $signed(dout_im), x.im);
         chk("mdl_sof", dout_sof, x.sof);
         chk("mdl_sat", sat, x.sat);
      end else begin
         chk("idle_vld", dout_vld, 0);
         chk("idle_sat", sat, 0);
      end
   end

   initial begin
      int oe, o1, o2;
      logic [15:0] ra, rb;
      tv[0] = '{0,  1000,   0,    998,    0,     1'b0};
      tv[1] = '{20, 1000,   0,    707,    -707,  1'b0};
      tv[2] = '{59, 0,      1000, -98,    -996,  1'b0};
      tv[3] = '{24, -32768, 0,    0,      32767, 1'b1};
      tv[4] = '{0,  -32768, 0,    -32704, 0,     1'b0};
      tv[5] = '{49, 1000,   0,    957,    -291,  1'b0};
      tv[6] = '{16, 1000,   0,    998,    0,     1'b0};

      #2;
      chk("reset_vld", dout_vld, 0);
      chk("reset_re", dout_re, 0);
      chk("reset_im", dout_im, 0);
      chk("reset_sof", dout_sof, 0);
      chk("reset_sat", sat, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Constant (1000, 0) frame: every address visible through the model
      for (int k = 0; k < 64; k++) drive(1'b1, k == 0, 1000, 0, oe);
      idle_until(oe);

      for (int i = 0; i < 7; i++) begin
         for (int k = 0; k <= tv[i].addr; k++)
            drive(1'b1, k == 0, (k == tv[i].addr) ? tv[i].a : 0, (k == tv[i].addr) ? tv[i].b : 0, oe);
         idle_until(oe);
         chk("vec_vld", dout_vld, 1);
         chk("vec_re", $signed(dout_re), tv[i].er);
         chk("vec_im", $signed(dout_im), tv[i].ei);
         chk("vec_sat", sat, tv[i].es);
      end

      // Resync: sof at position 37 forces address 0, the next sample takes address 1
      for (int k = 0; k < 37; k++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         drive(1'b1, k == 0, int'($signed(ra)), int'($signed(rb)), oe);
      end
      drive(1'b1, 1'b1, 1000, 0, o1);
      drive(1'b1, 1'b0, 1000, 0, o2);
      idle_until(o1);
      chk("resync_re", $signed(dout_re), 998);
      chk("resync_sof", dout_sof, 1);
      @(posedge clk);
      #1;
      chk("resync_next_re", $signed(dout_re), 998);
      chk("resync_next_sof", dout_sof, 0);

      // Two full frames with random data and random valid gaps
      for (int f = 0; f < 2; f++)
         for (int n = 0; n < 1024; n++) begin
            if ($urandom_range(3) == 0)
               repeat ($urandom_range(1, 3)) drive(1'b0, 1'b0, 0, 0, oe);
            ra = 16'($urandom);
            rb = 16'($urandom);
            drive(1'b1, n == 0, int'($signed(ra)), int'($signed(rb)), oe);
         end
      idle_until(oe);

      // Reset with two samples in flight
      drive(1'b1, 1'b1, 1000, 0, oe);
      drive(1'b1, 1'b0, 500, -300, oe);
      @(negedge clk);
      din_vld = 1'b0;
      din_sof = 1'b0;
      rst_n   = 1'b0;
      q.delete();
      m_idx = 0;
      #1;
      chk("midrst_vld", dout_vld, 0);
      chk("midrst_re", dout_re, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) begin
         @(posedge clk);
         #1;
         chk("postrst_vld", dout_vld, 0);
         chk("postrst_re", dout_re, 0);
         chk("postrst_im", dout_im, 0);
         chk("postrst_sof", dout_sof, 0);
      end
      drive(1'b1, 1'b1, 1000, 0, o1);
      for (int k = 1; k < 21; k++) drive(1'b1, 1'b0, 1000, 0, oe);
      idle_until(oe);
      chk("postrst_addr20_re", $signed(dout_re), 707);
      chk("postrst_addr20_im", $signed(dout_im), -707);

      repeat (10) if (q.size() != 0) @(posedge clk);
      #1;
      chk("drain", q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
